// File: rtl/game_sequencer.sv
// game_sequencer: per-frame raccoon/car game controller.
// Moves, collides and scores once per vsync, outside active video.
module game_sequencer #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int GRID_W      = 32,
  parameter int GRID_H      = 30,
  parameter int PLAYER_W    = 32,
  parameter int PLAYER_H    = 30,
  parameter int CAR_W       = 64,
  parameter int CAR_H       = 30,
  parameter int START_X     = 304,
  parameter int START_Y     = 450,
  parameter int CAR1_Y      = 90,
  parameter int CAR2_Y      = 150,
  parameter int CAR3_Y      = 300,
  parameter int START_LIVES = 3,
  parameter int HIT_FRAMES  = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vga_vs,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] raccoonX,
  output logic [9:0] raccoonY,
  output logic [9:0] carX_1,
  output logic [9:0] carY_1,
  output logic [9:0] carX_2,
  output logic [9:0] carY_2,
  output logic [9:0] carX_3,
  output logic [9:0] carY_3,
  output logic [1:0] lives,
  output logic [2:0] level,
  output logic       game_over,
  output logic       hit,
  output logic       level_up
);
  typedef enum logic [2:0] {
    S_WAIT, S_MOVE, S_CARS, S_CHECK, S_OVER
  } state_e;

  localparam logic [10:0] SW   = 11'(SCREEN_W);
  localparam logic [10:0] GW   = 11'(GRID_W);
  localparam logic [10:0] GH   = 11'(GRID_H);
  localparam logic [10:0] PW   = 11'(PLAYER_W);
  localparam logic [10:0] PH   = 11'(PLAYER_H);
  localparam logic [10:0] CW   = 11'(CAR_W);
  localparam logic [10:0] CH   = 11'(CAR_H);
  localparam logic [10:0] XMAX = 11'(SCREEN_W - PLAYER_W);
  localparam logic [10:0] YMAX = 11'(SCREEN_H - PLAYER_H);
  localparam logic [9:0]  SX   = 10'(START_X);
  localparam logic [9:0]  SY   = 10'(START_Y);
  localparam logic [9:0]  C1Y  = 10'(CAR1_Y);
  localparam logic [9:0]  C2Y  = 10'(CAR2_Y);
  localparam logic [9:0]  C3Y  = 10'(CAR3_Y);
  localparam logic [9:0]  C1X0 = 10'd0;
  localparam logic [9:0]  C2X0 = 10'd320;
  localparam logic [9:0]  C3X0 = 10'd160;
  localparam logic [1:0]  LIV0 = 2'(START_LIVES);
  localparam logic [4:0]  FRZ  = 5'(HIT_FRAMES);

  state_e      state_q, state_d;
  logic        vs_q, tick;
  logic [3:0]  btn, btn_q, rise;
  logic        pend_q, pend_d;
  logic [1:0]  dir_q, dir_d;
  logic [4:0]  frz_q, frz_d;
  logic [9:0]  rx_q, rx_d, ry_q, ry_d;
  logic [9:0]  c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic [1:0]  lives_q, lives_d;
  logic [2:0]  level_q, level_d;
  logic        hit_q, hit_d, lvl_q, lvl_d, over_q;
  logic [10:0] spd, mx, my;
  logic        move_ok, coll;

  function automatic logic [9:0] car_r(
    input logic [9:0] x, input logic [10:0] s);
    logic [10:0] t;
    t = {1'b0, x} + s;
    if (t >= SW) t = t - SW;
    return 10'(t);
  endfunction

  function automatic logic [9:0] car_l(
    input logic [9:0] x, input logic [10:0] s);
    logic [10:0] t;
    if ({1'b0, x} < s) t = {1'b0, x} + SW - s;
    else               t = {1'b0, x} - s;
    return 10'(t);
  endfunction

  function automatic logic ovl(
    input logic [9:0] px, input logic [9:0] py,
    input logic [9:0] cx, input logic [9:0] cy);
    return ({1'b0, px} < {1'b0, cx} + CW) &&
           ({1'b0, cx} < {1'b0, px} + PW) &&
           ({1'b0, py} < {1'b0, cy} + CH) &&
           ({1'b0, cy} < {1'b0, py} + PH);
  endfunction

  assign btn  = {btn_up, btn_down, btn_left, btn_right};
  assign rise = btn & ~btn_q;
  assign tick = vs_q & ~vga_vs;
  assign spd  = {8'b0, level_q} + 11'd1;
  assign coll = ovl(rx_q, ry_q, c1_q, C1Y) |
                ovl(rx_q, ry_q, c2_q, C2Y) |
                ovl(rx_q, ry_q, c3_q, C3Y);

  // Candidate position for the pending move and its bounds verdict
  always_comb begin
    mx = {1'b0, rx_q};
    my = {1'b0, ry_q};
    move_ok = 1'b0;
    unique case (dir_q)
      2'd0: begin
        move_ok = my >= GH;
        my = my - GH;
      end
      2'd1: begin
        my = my + GH;
        move_ok = my <= YMAX;
      end
      2'd2: begin
        move_ok = mx >= GW;
        mx = mx - GW;
      end
      default: begin
        mx = mx + GW;
        move_ok = mx <= XMAX;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_WAIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT:  if (tick) state_d = S_MOVE;
      S_MOVE:  state_d = S_CARS;
      S_CARS:  state_d = S_CHECK;
      S_CHECK: state_d = (coll && lives_q == 2'd1) ? S_OVER : S_WAIT;
      S_OVER:  if (|rise) state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  always_comb begin
    pend_d  = pend_q;
    dir_d   = dir_q;
    frz_d   = frz_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    c3_d    = c3_q;
    lives_d = lives_q;
    level_d = level_q;
    hit_d   = 1'b0;
    lvl_d   = 1'b0;
    unique case (state_q)
      S_MOVE: begin
        pend_d = 1'b0;
        if (frz_q != 5'd0) begin
          frz_d = frz_q - 5'd1;
        end else if (pend_q && move_ok) begin
          rx_d = 10'(mx);
          ry_d = 10'(my);
        end
      end
      S_CARS: begin
        c1_d = car_r(c1_q, spd);
        c2_d = car_l(c2_q, spd);
        c3_d = car_r(c3_q, spd);
      end
      S_CHECK: begin
        if (coll) begin
          hit_d   = 1'b1;
          lives_d = lives_q - 2'd1;
          rx_d    = SX;
          ry_d    = SY;
          frz_d   = FRZ;
          pend_d  = 1'b0;
        end else if (ry_q == 10'd0) begin
          lvl_d   = 1'b1;
          level_d = (level_q == 3'd7) ? level_q : level_q + 3'd1;
          rx_d    = SX;
          ry_d    = SY;
        end
      end
      S_OVER: begin
        if (|rise) begin
          lives_d = LIV0;
          level_d = 3'd0;
          rx_d    = SX;
          ry_d    = SY;
          c1_d    = C1X0;
          c2_d    = C2X0;
          c3_d    = C3X0;
          frz_d   = 5'd0;
          pend_d  = 1'b0;
        end
      end
      default: ;
    endcase
    // A fresh edge wins over the MOVE-cycle clear; a hit drops it
    if (|rise && frz_q == 5'd0 && state_q != S_OVER &&
        !(state_q == S_CHECK && coll)) begin
      pend_d = 1'b1;
      if (rise[3])      dir_d = 2'd0;
      else if (rise[2]) dir_d = 2'd1;
      else if (rise[1]) dir_d = 2'd2;
      else              dir_d = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b1;
      btn_q   <= 4'd0;
      pend_q  <= 1'b0;
      dir_q   <= 2'd0;
      frz_q   <= 5'd0;
      rx_q    <= SX;
      ry_q    <= SY;
      c1_q    <= C1X0;
      c2_q    <= C2X0;
      c3_q    <= C3X0;
      lives_q <= LIV0;
      level_q <= 3'd0;
      hit_q   <= 1'b0;
      lvl_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      vs_q    <= vga_vs;
      btn_q   <= btn;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      frz_q   <= frz_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      c3_q    <= c3_d;
      lives_q <= lives_d;
      level_q <= level_d;
      hit_q   <= hit_d;
      lvl_q   <= lvl_d;
      over_q  <= (state_d == S_OVER);
    end
  end

  assign raccoonX  = rx_q;
  assign raccoonY  = ry_q;
  assign carX_1    = c1_q;
  assign carX_2    = c2_q;
  assign carX_3    = c3_q;
  assign carY_1    = C1Y;
  assign carY_2    = C2Y;
  assign carY_3    = C3Y;
  assign lives     = lives_q;
  assign level     = level_q;
  assign game_over = over_q;
  assign hit       = hit_q;
  assign level_up  = lvl_q;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed frame-by-frame checks of game_sequencer.
// Car positions are tracked by a small wrap-around model.
module tb_game_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, vga_vs;
  logic [3:0] btns;
  logic [9:0] raccoonX, raccoonY;
  logic [9:0] carX_1, carY_1, carX_2, carY_2, carX_3, carY_3;
  logic [1:0] lives;
  logic [2:0] level;
  logic       game_over, hit, level_up;

  int n_run = 0, n_fail = 0;
  int hit_cnt = 0, lvl_cnt = 0;
  int m1, m2, m3, mlvl;
  bit mfrz;

  game_sequencer dut (
    .clk(clk), .rst_n(rst_n), .vga_vs(vga_vs),
    .btn_up(btns[3]), .btn_down(btns[2]),
    .btn_left(btns[1]), .btn_right(btns[0]),
    .raccoonX(raccoonX), .raccoonY(raccoonY),
    .carX_1(carX_1), .carY_1(carY_1),
    .carX_2(carX_2), .carY_2(carY_2),
    .carX_3(carX_3), .carY_3(carY_3),
    .lives(lives), .level(level),
    .game_over(game_over), .hit(hit), .level_up(level_up)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (hit === 1'b1) hit_cnt++;
    if (level_up === 1'b1) lvl_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m1 = 0; m2 = 320; m3 = 160; mlvl = 0; mfrz = 0;
  endtask

  task automatic model_step();
    int s;
    if (!mfrz) begin
      s = mlvl + 1;
      m1 = m1 + s; if (m1 >= 640) m1 = m1 - 640;
      m2 = m2 - s; if (m2 < 0)    m2 = m2 + 640;
      m3 = m3 + s; if (m3 >= 640) m3 = m3 - 640;
    end
  endtask

  task automatic chk_cars(input string tag);
    chk({tag, "_c1"}, carX_1, m1);
    chk({tag, "_c2"}, carX_2, m2);
    chk({tag, "_c3"}, carX_3, m3);
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge clk) btns = mask;
    @(negedge clk) btns = 4'd0;
    @(negedge clk);
  endtask

  task automatic do_tick(input bit lat, input int yb, input int ya);
    @(negedge clk) vga_vs = 1'b0;
    @(negedge clk);
    if (lat) chk("lat_t1", raccoonY, yb);
    @(negedge clk);
    if (lat) chk("lat_t2", raccoonY, ya);
    vga_vs = 1'b1;
    repeat (4) @(negedge clk);
    model_step();
  endtask

  task automatic move_n(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      press(mask);
      do_tick(1'b0, 0, 0);
    end
  endtask

  task automatic wait_car(input int which, input int val);
    int cur;
    for (int i = 0; i < 700; i++) begin
      cur = (which == 1) ? m1 : (which == 2) ? m2 : m3;
      if (cur == val) break;
      do_tick(1'b0, 0, 0);
    end
    if (which == 1)      chk("wait_c1", carX_1, val);
    else if (which == 2) chk("wait_c2", carX_2, val);
    else                 chk("wait_c3", carX_3, val);
  endtask

  initial begin
    rst_n = 1'b0; vga_vs = 1'b1; btns = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rx", raccoonX, 304);
    chk("rst_ry", raccoonY, 450);
    chk("rst_c1", carX_1, 0);
    chk("rst_c2", carX_2, 320);
    chk("rst_c3", carX_3, 160);
    chk("rst_cy1", carY_1, 90);
    chk("rst_cy2", carY_2, 150);
    chk("rst_cy3", carY_3, 300);
    chk("rst_lives", lives, 3);
    chk("rst_level", level, 0);
    chk("rst_over", game_over, 0);
    chk("rst_hit", hit, 0);
    chk("rst_lvlup", level_up, 0);

    do_tick(1'b0, 0, 0);
    do_tick(1'b0, 0, 0);
    chk("t2_c1", carX_1, 2);
    chk("t2_c2", carX_2, 318);
    chk("t2_c3", carX_3, 162);
    chk("t2_rx", raccoonX, 304);
    chk("t2_ry", raccoonY, 450);
    chk("t2_lives", lives, 3);
    chk("t2_level", level, 0);

    press(4'b1000);
    do_tick(1'b1, 450, 420);
    press(4'b0100);
    do_tick(1'b0, 0, 0);
    chk("down_ry", raccoonY, 450);
    press(4'b0100);
    do_tick(1'b1, 450, 450);
    chk("down_bound_rx", raccoonX, 304);
    chk_cars("mv");

    press(4'b1011);
    do_tick(1'b0, 0, 0);
    chk("prio_ry", raccoonY, 420);
    chk("prio_rx", raccoonX, 304);
    press(4'b0010);
    press(4'b0100);
    do_tick(1'b0, 0, 0);
    chk("ovw_ry", raccoonY, 450);
    chk("ovw_rx", raccoonX, 304);

    move_n(4'b0010, 9);
    chk("left9_rx", raccoonX, 16);
    move_n(4'b0010, 1);
    chk("left_bound", raccoonX, 16);
    move_n(4'b0001, 18);
    chk("right18_rx", raccoonX, 592);
    move_n(4'b0001, 1);
    chk("right_bound", raccoonX, 592);
    move_n(4'b0010, 9);
    chk("back_rx", raccoonX, 304);

    wait_car(2, 0);
    do_tick(1'b0, 0, 0);
    chk("wrap_c2", carX_2, 639);
    wait_car(1, 639);
    do_tick(1'b0, 0, 0);
    chk("wrap_c1", carX_1, 0);
    chk_cars("wrap");

    wait_car(1, 260);
    move_n(4'b1000, 11);
    chk("pre_hit_ry", raccoonY, 120);
    chk("pre_hit_cnt", hit_cnt, 0);
    move_n(4'b1000, 1);
    chk("hit1_cnt", hit_cnt, 1);
    chk("hit1_lives", lives, 2);
    chk("hit1_rx", raccoonX, 304);
    chk("hit1_ry", raccoonY, 450);
    chk("hit1_over", game_over, 0);

    for (int i = 0; i < 30; i++) begin
      press(4'b1000);
      do_tick(1'b0, 0, 0);
      chk("frz_ry", raccoonY, 450);
    end
    move_n(4'b1000, 1);
    chk("frz_done_ry", raccoonY, 420);

    move_n(4'b1000, 3);
    chk("h2_ry", raccoonY, 330);
    wait_car(3, 289);
    move_n(4'b1000, 1);
    chk("hit2_cnt", hit_cnt, 2);
    chk("hit2_lives", lives, 1);
    chk("hit2_ry", raccoonY, 450);

    for (int i = 0; i < 30; i++) do_tick(1'b0, 0, 0);
    move_n(4'b1000, 4);
    chk("h3_ry", raccoonY, 330);
    wait_car(3, 289);
    move_n(4'b1000, 1);
    mfrz = 1;
    chk("hit3_cnt", hit_cnt, 3);
    chk("hit3_lives", lives, 0);
    chk("hit3_over", game_over, 1);
    chk("hit3_rx", raccoonX, 304);
    chk("hit3_ry", raccoonY, 450);

    for (int i = 0; i < 5; i++) do_tick(1'b0, 0, 0);
    chk_cars("over");
    chk("over_ry", raccoonY, 450);
    chk("over_hold", game_over, 1);

    press(4'b0010);
    model_reset();
    chk("rs_lives", lives, 3);
    chk("rs_level", level, 0);
    chk("rs_over", game_over, 0);
    chk("rs_rx", raccoonX, 304);
    chk("rs_ry", raccoonY, 450);
    chk_cars("rs");

    for (int i = 0; i < 200; i++) do_tick(1'b0, 0, 0);
    chk_cars("idle");
    move_n(4'b1000, 14);
    chk("lv_ry14", raccoonY, 30);
    move_n(4'b1000, 1);
    mlvl = 1;
    chk("lv_cnt", lvl_cnt, 1);
    chk("lv_level", level, 1);
    chk("lv_rx", raccoonX, 304);
    chk("lv_ry", raccoonY, 450);
    chk("lv_hits", hit_cnt, 3);
    chk("lv_c1_pre", carX_1, 215);
    do_tick(1'b0, 0, 0);
    chk("spd2_c1", carX_1, 217);
    chk("spd2_c2", carX_2, 103);
    chk("spd2_c3", carX_3, 377);
    chk_cars("spd2");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
